parking_lot_counter: RTL and testbench
======================================

Name: parking_lot_counter

Overview:
- Sequential producer feeding the parking-lot HEX display.
- Watches two gate photo-sensors (outer `a`, inner `b`) and decodes car entry and exit sequences with an FSM.
- Keeps the occupancy count `cars` plus its BCD ones/tens digits (`count1`, `count10`). These drive the display's inputs directly.
- Saturates at 0 and at CAPACITY, and flags rejected events.

Parameters:
CAPACITY, 25, maximum occupancy; range 1..99.
CW, $clog2(CAPACITY+1) = 5, width of `cars`.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
a  input  1  outer sensor, 1 = beam blocked; asynchronous to clk.
b  input  1  inner sensor, 1 = beam blocked; asynchronous to clk.
cars  output  CW  current occupancy, 0..CAPACITY.
count1  output  4  BCD ones digit of cars.
count10  output  4  BCD tens digit of cars.
enter  output  1  one-cycle pulse: valid entry decoded.
exit  output  1  one-cycle pulse: valid exit decoded.
reject  output  1  one-cycle pulse: entry at full or exit at empty; count unchanged.
full  output  1  cars == CAPACITY.
empty  output  1  cars == 0.

Behaviour:
- Reset, synchronous, active-high, applied on the clk edge while reset=1:
  - state=IDLE, sync flops=0, cars=0, count1=0, count10=0.
  - enter=exit=reject=0, full=0, empty=1.
  - Reset mid-sequence abandons the sequence with no pulse.
- Input sync: a and b each pass a 2-flop synchronizer. The FSM sees ab={a_s,b_s}.
- FSM states are IDLE, EN1, EN2, EN3, EX1, EX2, EX3. Any unlisted ab value holds the current state.
  - IDLE: 10->EN1, 01->EX1; 11 is ignored (stay).
  - EN1: 11->EN2, 00->IDLE (backed out), 01->IDLE.
  - EN2: 01->EN3, 10->EN1 (reversing), 00->IDLE.
  - EN3: 00->IDLE and fire entry event; 11->EN2; 10->IDLE.
  - EX1: 11->EX2, 00->IDLE, 10->IDLE.
  - EX2: 10->EX3, 01->EX1, 00->IDLE.
  - EX3: 00->IDLE and fire exit event; 11->EX2; 01->IDLE.
- At most one event per cycle; entry and exit are mutually exclusive by construction.
- Latency:
  - The event is registered on the same edge the FSM leaves EN3/EX3.
  - enter/exit/reject and the updated cars/count1/count10 all become visible together, in the cycle after that edge.
  - Total is 3 clk edges after raw ab reaches 00 (2 sync + 1 FSM).
  - Pulses last exactly 1 cycle.
- Arithmetic:
  - Entry with cars<CAPACITY: cars+1, enter=1.
  - Entry with cars==CAPACITY: no change, reject=1, enter=0.
  - Exit with cars>0: cars-1, exit=1.
  - Exit with cars==0: no change, reject=1, exit=0.
- BCD digits are tracked incrementally, with no divider:
  - Increment: count1 9->0 carries into count10+1.
  - Decrement: count1 0->9 borrows from count10-1.
  - Invariant every cycle: 10*count10 + count1 == cars, each digit in 0..9.
- full and empty are registered and updated on the same edge as cars.

Decomposition:
- Package parking_pkg holds:
  - typedef enum logic [2:0] gate_state_t {IDLE, EN1, EN2, EN3, EX1, EX2, EX3};
  - typedef enum logic [1:0] gate_evt_t {EVT_NONE, EVT_ENTER, EVT_EXIT};
  - localparam default CAPACITY = 25.
- Sub-module gate_fsm holds the synchronizers and the sequence FSM, and emits a 1-cycle gate_evt_t.
- The top level holds the saturating counter, BCD digits, flags and pulses.

Test Plan:
1. Reset; drive ab 00,10,11,01,00 holding each value 3 cycles -> exactly one enter pulse, 3 edges after the final 00; cars=1, count1=1, count10=0, empty=0.
2. From cars=1, drive 00,01,11,10,00 -> exit pulse; cars=0, count1=0, count10=0, empty=1.
3. Ten entries -> at the 10th: count1 9->0, count10=1, cars=10. Then one exit -> count1=9, count10=0, cars=9.
4. Reach 25 entries -> full=1, count10=2, count1=5. A 26th entry -> reject=1, enter=0, cars stays 25.
5. Back-out 00,10,11,10,00 and glitch 00,11,00 -> no pulses, cars unchanged, FSM returns to IDLE.
6. Assert reset while in EN2 with cars=7 -> next cycle cars=0, IDLE, no pulse. An exit sequence at cars=0 then gives reject=1, cars=0.

Source files
------------

// File: rtl/parking_lot_counter_pkg.sv
// Shared types for the parking-lot gate decoder and occupancy counter.
// The gate FSM states, the event it reports, and the default lot size.
package parking_pkg;

   typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} gate_state_t;
   typedef enum logic [1:0] {EVT_NONE, EVT_ENTER, EVT_EXIT} gate_evt_t;

   localparam int DEFAULT_CAPACITY = 25;

endpackage

// File: rtl/parking_lot_counter_if.sv
// Bundle between the gate sensors / HEX display side and the occupancy counter.
// There is no handshake: sensors are levels, enter/exit/reject are 1-cycle pulses.
interface parking_lot_counter_if #(parameter int CW = 5);
   import parking_pkg::*;

   logic          a;
   logic          b;
   logic [CW-1:0] cars;
   logic [3:0]    count1;
   logic [3:0]    count10;
   logic          enter;
   logic          exit;
   logic          reject;
   logic          full;
   logic          empty;
   gate_state_t   fsm_state;

   modport master (
      output a, b,
      input  cars, count1, count10, enter, exit, reject, full, empty, fsm_state
   );

   modport slave (
      input  a, b,
      output cars, count1, count10, enter, exit, reject, full, empty, fsm_state
   );

endinterface

// File: rtl/parking_lot_counter_gate_fsm.sv
// Synchronises the two beam sensors and decodes entry/exit crossing sequences.
// evt is combinational: it is high in the cycle whose edge leaves EN3/EX3.
module gate_fsm
   import parking_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        a,
   input  logic        b,
   output gate_evt_t   evt,
   output gate_state_t state_dbg
);

   logic        a_m, a_s, b_m, b_s;
   logic [1:0]  ab;
   gate_state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_m     <= 1'b0;
         a_s     <= 1'b0;
         b_m     <= 1'b0;
         b_s     <= 1'b0;
         state_q <= IDLE;
      end else begin
         a_m     <= a;
         a_s     <= a_m;
         b_m     <= b;
         b_s     <= b_m;
         state_q <= state_d;
      end
   end

   assign ab        = {a_s, b_s};
   assign state_dbg = state_q;

   // Any ab value not named in a state's case holds that state.
   always_comb begin
      state_d = state_q;
      evt     = EVT_NONE;
      case (state_q)
         IDLE: case (ab)
            2'b10:   state_d = EN1;
            2'b01:   state_d = EX1;
            default: ;
         endcase
         EN1: case (ab)
            2'b11:   state_d = EN2;
            2'b00:   state_d = IDLE;
            2'b01:   state_d = IDLE;
            default: ;
         endcase
         EN2: case (ab)
            2'b01:   state_d = EN3;
            2'b10:   state_d = EN1;
            2'b00:   state_d = IDLE;
            default: ;
         endcase
         EN3: case (ab)
            2'b00: begin
               state_d = IDLE;
               evt     = EVT_ENTER;
            end
            2'b11:   state_d = EN2;
            2'b10:   state_d = IDLE;
            default: ;
         endcase
         EX1: case (ab)
            2'b11:   state_d = EX2;
            2'b00:   state_d = IDLE;
            2'b10:   state_d = IDLE;
            default: ;
         endcase
         EX2: case (ab)
            2'b10:   state_d = EX3;
            2'b01:   state_d = EX1;
            2'b00:   state_d = IDLE;
            default: ;
         endcase
         EX3: case (ab)
            2'b00: begin
               state_d = IDLE;
               evt     = EVT_EXIT;
            end
            2'b11:   state_d = EX2;
            2'b01:   state_d = IDLE;
            default: ;
         endcase
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/parking_lot_counter.sv
// Saturating occupancy counter with incremental BCD digits and status flags.
// Gate events from gate_fsm are registered here, so pulses and count move together.
module parking_lot_counter
   import parking_pkg::*;
#(
   parameter int CAPACITY = DEFAULT_CAPACITY,
   parameter int CW       = $clog2(CAPACITY + 1)
)
(
   input logic                 clk,
   input logic                 reset,
   parking_lot_counter_if.slave bus
);

   localparam logic [CW-1:0] CAP_M1 = CW'(CAPACITY - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   gate_evt_t     evt;
   logic [CW-1:0] cars_q;
   logic [3:0]    count1_q, count10_q;
   logic          enter_q, exit_q, reject_q, full_q, empty_q;

   gate_fsm u_gate (
      .clk       (clk),
      .reset     (reset),
      .a         (bus.a),
      .b         (bus.b),
      .evt       (evt),
      .state_dbg (bus.fsm_state)
   );

   // full_q/empty_q always mirror cars_q, so they double as the saturation tests.
   always_ff @(posedge clk) begin
      if (reset) begin
         cars_q    <= '0;
         count1_q  <= 4'd0;
         count10_q <= 4'd0;
         enter_q   <= 1'b0;
         exit_q    <= 1'b0;
         reject_q  <= 1'b0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         enter_q  <= 1'b0;
         exit_q   <= 1'b0;
         reject_q <= 1'b0;
         case (evt)
            EVT_ENTER: begin
               if (full_q) begin
                  reject_q <= 1'b1;
               end else begin
                  enter_q <= 1'b1;
                  cars_q  <= cars_q + 1'b1;
                  full_q  <= (cars_q == CAP_M1);
                  empty_q <= 1'b0;
                  if (count1_q == 4'd9) begin
                     count1_q  <= 4'd0;
                     count10_q <= count10_q + 4'd1;
                  end else begin
                     count1_q  <= count1_q + 4'd1;
                  end
               end
            end
            EVT_EXIT: begin
               if (empty_q) begin
                  reject_q <= 1'b1;
               end else begin
                  exit_q  <= 1'b1;
                  cars_q  <= cars_q - 1'b1;
                  full_q  <= 1'b0;
                  empty_q <= (cars_q == ONE);
                  if (count1_q == 4'd0) begin
                     count1_q  <= 4'd9;
                     count10_q <= count10_q - 4'd1;
                  end else begin
                     count1_q  <= count1_q - 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cars    = cars_q;
   assign bus.count1  = count1_q;
   assign bus.count10 = count10_q;
   assign bus.enter   = enter_q;
   assign bus.exit    = exit_q;
   assign bus.reject  = reject_q;
   assign bus.full    = full_q;
   assign bus.empty   = empty_q;

endmodule

// File: tb/tb_parking_lot_counter.sv
// Bench for parking_lot_counter: directed vector table, hand-written corner
// sequences and randomized gate traffic, all checked against a crossing-path model.
module tb_parking_lot_counter;
   import parking_pkg::*;

   localparam int CAP = 25;
   localparam int CW  = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   parking_lot_counter_if #(.CW(CW)) bus ();

   parking_lot_counter #(.CAPACITY(CAP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_en, n_ex, n_rej;

   // Reference model: position along the crossing path 00 -> x -> 11 -> y -> 00.
   int         m_cars, m_dir, m_pos;
   logic       m_en, m_ex, m_rej;
   logic [1:0] exp_q[$];

   typedef struct {
      logic [15:0] seq;
      int          len;
      int          exp_en;
      int          exp_ex;
      int          exp_rej;
      int          exp_cars;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] path_at(input int dir, input int pos);
      logic [1:0] p[5];
      if (dir == 1) p = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
      else          p = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
      return p[pos];
   endfunction

   function automatic gate_state_t m_state();
      gate_state_t s;
      s = IDLE;
      if (m_dir == 1) s = (m_pos == 1) ? EN1 : (m_pos == 2) ? EN2 : EN3;
      if (m_dir == 2) s = (m_pos == 1) ? EX1 : (m_pos == 2) ? EX2 : EX3;
      return s;
   endfunction

   task automatic model_reset();
      m_cars = 0;
      m_dir  = 0;
      m_pos  = 0;
      m_en   = 1'b0;
      m_ex   = 1'b0;
      m_rej  = 1'b0;
      exp_q  = '{2'b00, 2'b00};
   endtask

   task automatic model_step(input logic [1:0] raw);
      logic [1:0] ab;
      int evt;
      ab = exp_q.pop_front();
      exp_q.push_back(raw);
      evt   = 0;
      m_en  = 1'b0;
      m_ex  = 1'b0;
      m_rej = 1'b0;
      if (m_dir == 0) begin
         if (ab == 2'b10) begin m_dir = 1; m_pos = 1; end
         else if (ab == 2'b01) begin m_dir = 2; m_pos = 1; end
      end else if (ab == path_at(m_dir, m_pos + 1)) begin
         m_pos++;
         if (m_pos == 4) begin evt = m_dir; m_dir = 0; m_pos = 0; end
      end else if (ab == path_at(m_dir, m_pos - 1)) begin
         m_pos--;
         if (m_pos == 0) m_dir = 0;
      end else if (ab != path_at(m_dir, m_pos)) begin
         m_dir = 0;
         m_pos = 0;
      end
      if (evt == 1) begin
         if (m_cars == CAP) m_rej = 1'b1;
         else begin m_cars++; m_en = 1'b1; end
      end else if (evt == 2) begin
         if (m_cars == 0) m_rej = 1'b1;
         else begin m_cars--; m_ex = 1'b1; end
      end
   endtask

   task automatic compare_all();
      check("cars",    32'(bus.cars),      32'(m_cars));
      check("count1",  32'(bus.count1),    32'(m_cars % 10));
      check("count10", 32'(bus.count10),   32'(m_cars / 10));
      check("enter",   32'(bus.enter),     32'(m_en));
      check("exit",    32'(bus.exit),      32'(m_ex));
      check("reject",  32'(bus.reject),    32'(m_rej));
      check("full",    32'(bus.full),      32'(m_cars == CAP));
      check("empty",   32'(bus.empty),     32'(m_cars == 0));
      check("state",   32'(bus.fsm_state), 32'(m_state()));
   endtask

   task automatic step(input logic [1:0] ab);
      bus.a = ab[1];
      bus.b = ab[0];
      @(posedge clk);
      model_step(ab);
      #1;
      compare_all();
      n_en  += int'(bus.enter);
      n_ex  += int'(bus.exit);
      n_rej += int'(bus.reject);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      model_reset();
      #1;
      compare_all();
      reset = 1'b0;
   endtask

   task automatic clear_counts();
      n_en  = 0;
      n_ex  = 0;
      n_rej = 0;
   endtask

   task automatic pass(input bit is_entry, input int hmin, input int hmax);
      logic [1:0] mid;
      mid = is_entry ? 2'b10 : 2'b01;
      repeat ($urandom_range(hmax, hmin)) step(2'b00);
      repeat ($urandom_range(hmax, hmin)) step(mid);
      repeat ($urandom_range(hmax, hmin)) step(2'b11);
      repeat ($urandom_range(hmax, hmin)) step(~mid);
      repeat (4) step(2'b00);
   endtask

   initial begin
      reset = 1'b1;
      bus.a = 1'b0;
      bus.b = 1'b0;
      model_reset();

      // Entry 00,10,11,01,00 / exit 00,01,11,10,00, 2 bits per value from the MSB.
      vecs[0] = '{16'h2D00, 5, 1, 0, 0, 1};
      vecs[1] = '{16'h1E00, 5, 0, 1, 0, 0};
      vecs[2] = '{16'h1E00, 5, 0, 0, 1, 0};
      vecs[3] = '{16'h2E00, 5, 0, 0, 0, 0};
      vecs[4] = '{16'h3000, 3, 0, 0, 0, 0};
      vecs[5] = '{16'h2D00, 5, 1, 0, 0, 1};
      vecs[6] = '{16'h2ED0, 7, 1, 0, 0, 2};

      // Entry latency: pulse lands on the third edge after raw ab returns to 00.
      do_reset();
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_full",  32'(bus.full),  32'd0);
      repeat (3) step(2'b10);
      repeat (3) step(2'b11);
      repeat (3) step(2'b01);
      step(2'b00);
      check("lat_e1", 32'(bus.enter), 32'd0);
      step(2'b00);
      check("lat_e2", 32'(bus.enter), 32'd0);
      step(2'b00);
      check("lat_e3", 32'(bus.enter), 32'd1);
      check("lat_cars", 32'(bus.cars), 32'd1);
      step(2'b00);
      check("lat_pulse_len", 32'(bus.enter), 32'd0);

      do_reset();
      for (int v = 0; v < 7; v++) begin
         clear_counts();
         for (int k = 0; k < vecs[v].len; k++)
            repeat (3) step(vecs[v].seq[15 - 2*k -: 2]);
         repeat (3) step(2'b00);
         check($sformatf("vec%0d_enter", v),  32'(n_en),     32'(vecs[v].exp_en));
         check($sformatf("vec%0d_exit", v),   32'(n_ex),     32'(vecs[v].exp_ex));
         check($sformatf("vec%0d_reject", v), 32'(n_rej),    32'(vecs[v].exp_rej));
         check($sformatf("vec%0d_cars", v),   32'(bus.cars), 32'(vecs[v].exp_cars));
         check($sformatf("vec%0d_idle", v),   32'(bus.fsm_state), 32'(IDLE));
      end

      // BCD carry at 10, borrow on the way back.
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         pass(1'b1, 2, 2);
         if (i == 9) check("bcd9_ones", 32'(bus.count1), 32'd9);
      end
      check("bcd10_ones", 32'(bus.count1),  32'd0);
      check("bcd10_tens", 32'(bus.count10), 32'd1);
      check("bcd10_cars", 32'(bus.cars),    32'd10);
      pass(1'b0, 2, 2);
      check("borrow_ones", 32'(bus.count1),  32'd9);
      check("borrow_tens", 32'(bus.count10), 32'd0);
      check("borrow_cars", 32'(bus.cars),    32'd9);

      // Fill to capacity, then one entry too many.
      for (int i = 9; i < CAP; i++) pass(1'b1, 1, 2);
      check("cap_full", 32'(bus.full),    32'd1);
      check("cap_tens", 32'(bus.count10), 32'd2);
      check("cap_ones", 32'(bus.count1),  32'd5);
      clear_counts();
      pass(1'b1, 2, 2);
      check("over_reject", 32'(n_rej),    32'd1);
      check("over_enter",  32'(n_en),     32'd0);
      check("over_cars",   32'(bus.cars), 32'd25);

      // Reset in the middle of an entry sequence.
      do_reset();
      for (int i = 0; i < 7; i++) pass(1'b1, 1, 3);
      check("mid_cars7", 32'(bus.cars), 32'd7);
      repeat (3) step(2'b10);
      repeat (3) step(2'b11);
      check("mid_en2", 32'(bus.fsm_state), 32'(EN2));
      do_reset();
      check("mid_rst_cars",  32'(bus.cars),      32'd0);
      check("mid_rst_state", 32'(bus.fsm_state), 32'(IDLE));
      check("mid_rst_enter", 32'(bus.enter),     32'd0);
      clear_counts();
      pass(1'b0, 2, 2);
      check("empty_exit_reject", 32'(n_rej),    32'd1);
      check("empty_exit_pulse",  32'(n_ex),     32'd0);
      check("empty_exit_cars",   32'(bus.cars), 32'd0);

      // Random traffic biased toward entries so saturation is exercised.
      do_reset();
      for (int it = 0; it < 90; it++) begin
         case ($urandom_range(4, 0))
            0, 1, 2: pass(1'b1, 1, 3);
            3:       pass(1'b0, 1, 3);
            default: repeat (4) repeat ($urandom_range(3, 1)) step(2'($urandom_range(3, 0)));
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
